uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame controller for the UART transmitter. It accepts a byte handshake, computes the parity bit, and sequences the serializer through its 8 data bits via `ser_en`/`ser_done`. It drives the serial line through an internal start/data/parity/stop output mux. It sits beside the serializer inside the UART TX top, and both blocks share `CLK`, `RST`, `P_DATA` and `Data_Valid`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: byte width. Must equal the serializer width. The serializer's `ser_done` fires at count 7, so 8 is the only supported value.

Ports:
- `CLK`  in  1  bit-rate clock; one bit period per cycle.
- `RST`  in  1  reset; synchronous, active-low.
- `P_DATA`  in  8  byte to send; used here only for parity.
- `Data_Valid`  in  1  byte-valid strobe from upstream.
- `PAR_EN`  in  1  1 = insert a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `ser_done`  in  1  from serializer; high on the 8th `ser_en` cycle.
- `ser_data`  in  1  current serializer LSB.
- `ser_en`  out  1  serializer shift/count enable.
- `Busy`  out  1  frame in progress; also gates the serializer load.
- `TX_OUT`  out  1  serial line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance happens when the state is IDLE and `Data_Valid` is high. This is the same edge at which the serializer loads (`Data_Valid && !Busy`). On acceptance the block latches:
  - `par_bit` = `^P_DATA` for even parity, or `~^P_DATA` for odd parity.
  - `PAR_EN` into `par_en_q`.
- State transitions:
  - IDLE → START on acceptance; otherwise stay in IDLE.
  - START → DATA unconditionally.
  - DATA → PARITY when `ser_done` is high and `par_en_q` = 1.
  - DATA → STOP when `ser_done` is high and `par_en_q` = 0.
  - DATA → DATA otherwise.
  - PARITY → STOP.
  - STOP → IDLE.
- `ser_en` = 1 only in DATA.
- `Busy` = 1 in every state except IDLE. It is decoded from the state register only.
- `TX_OUT` per state:
  - IDLE: 1
  - START: 0
  - DATA: `ser_data`
  - PARITY: `par_bit`
  - STOP: 1
- `TX_OUT` is a mux of registered signals only. It has no combinational path from `Data_Valid`, `PAR_EN` or `PAR_TYP`.
- `Data_Valid`, `PAR_EN` and `PAR_TYP` are ignored while `Busy` = 1. There is no queueing; upstream holds or drops.
- Changing `PAR_EN` or `PAR_TYP` mid-frame has no effect on the current frame.

## Timing
- Reset (`RST` low at a `CLK` edge) → state IDLE, `TX_OUT`=1, `Busy`=0, `ser_en`=0, `par_bit`=0, `par_en_q`=0. A reset mid-frame aborts the frame at that edge; the line returns to 1 with no stop bit.
- Acceptance at edge E0. START is visible in cycle E0→E1. DATA bits 0..7 occupy the following 8 cycles, LSB first. Parity, if enabled, takes 1 cycle, then STOP takes 1 cycle.
- Frame length after acceptance: 10 cycles without parity, 11 with parity.
- At least one IDLE cycle separates frames. The minimum acceptance-to-acceptance spacing is 11 cycles (no parity) or 12 cycles (parity).
- `ser_done` is sampled only in DATA. A spurious `ser_done` in any other state is ignored.
- In the DATA cycle where `ser_done` is high, `TX_OUT` carries data bit 7.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum (3-bit, binary: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - the mux-select constants;
  - the parity-type constants (`PAR_EVEN`=0, `PAR_ODD`=1).
- One sub-module, `parity_calc`: combinational, takes `P_DATA` and `PAR_TYP`, outputs the parity bit. It is instantiated here and latched on acceptance.
- The FSM register, the latches and the output mux stay in `uart_tx_ctrl`.

## Test plan
- Send `P_DATA`=0xA5 with `PAR_EN`=0. Required: `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; `Busy` high for exactly those 10 cycles; `ser_en` high for exactly 8 cycles.
- Send 0x07 with `PAR_EN`=1 and `PAR_TYP`=0, then 0x07 with `PAR_TYP`=1. Required: parity bit 1 in the first frame, 0 in the second; each frame is 11 cycles.
- Hold `Data_Valid` high continuously with `P_DATA`=0x3C, then 0xC3. Required: the second byte is accepted only in the IDLE cycle after STOP, at acceptance spacing 11 cycles; no byte is sent twice or corrupted.
- Pulse `Data_Valid` at cycles 3 and 6 of a frame with `P_DATA`=0xFF, and toggle `PAR_TYP` mid-frame. Required: the current frame is unchanged and no extra frame follows.
- Drive `RST` low during DATA bit 4. Required: at the next edge `TX_OUT`=1, `Busy`=0, `ser_en`=0; a new byte 0x55 sent after release produces a clean, complete frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
package uart_tx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [1:0] MUX_START = 2'd0;
    localparam logic [1:0] MUX_STOP  = 2'd1;
    localparam logic [1:0] MUX_SER   = 2'd2;
    localparam logic [1:0] MUX_PAR   = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic par_typ);
        logic p;
        if (par_typ == PAR_ODD) begin
            p = ~^data;
        end else begin
            p = ^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator for the byte presented at acceptance.
module parity_calc
    import uart_tx_pkg::*;
(
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              PAR_TYP,
    output logic              par_bit_o
);

    assign par_bit_o = calc_parity(P_DATA, PAR_TYP);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start/data/parity/stop sequencing and line mux.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  Busy,
    output logic                  TX_OUT
);

    state_e     state_q, state_d;
    logic       par_bit_q, par_bit_d;
    logic       par_en_q, par_en_d;
    logic       par_calc_s;
    logic       accept_s;
    logic [1:0] mux_sel_s;

    parity_calc u_parity_calc (
        .P_DATA    (P_DATA),
        .PAR_TYP   (PAR_TYP),
        .par_bit_o (par_calc_s)
    );

    assign accept_s = (state_q == ST_IDLE) && Data_Valid;

    // State and frame-configuration registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
        end
    end

    // Next state, parity capture and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        ser_en    = 1'b0;
        Busy      = 1'b1;
        mux_sel_s = MUX_STOP;

        if (accept_s) begin
            par_bit_d = par_calc_s;
            par_en_d  = PAR_EN;
        end else begin
            par_bit_d = par_bit_q;
            par_en_d  = par_en_q;
        end

        case (state_q)
            ST_IDLE: begin
                Busy      = 1'b0;
                mux_sel_s = MUX_STOP;
                if (accept_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                mux_sel_s = MUX_START;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                ser_en    = 1'b1;
                mux_sel_s = MUX_SER;
                // ser_done coincides with bit 7 on the line, so leave after this cycle.
                if (ser_done && par_en_q) begin
                    state_d = ST_PARITY;
                end else if (ser_done) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                mux_sel_s = MUX_PAR;
                state_d   = ST_STOP;
            end
            ST_STOP: begin
                mux_sel_s = MUX_STOP;
                state_d   = ST_IDLE;
            end
            default: begin
                Busy      = 1'b0;
                mux_sel_s = MUX_STOP;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Line mux; every source is a register (state, parity latch, serializer LSB).
    always_comb begin
        TX_OUT = 1'b1;
        case (mux_sel_s)
            MUX_START: TX_OUT = 1'b0;
            MUX_STOP:  TX_OUT = 1'b1;
            MUX_SER:   TX_OUT = ser_data;
            MUX_PAR:   TX_OUT = par_bit_q;
            default:   TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural serializer beside it.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_done;
    logic       ser_data;
    logic       ser_en;
    logic       Busy;
    logic       TX_OUT;

    logic       force_done;
    logic [7:0] sreg;
    logic [2:0] scnt;

    int errors = 0;
    int checks = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .Busy       (Busy),
        .TX_OUT     (TX_OUT)
    );

    always #5 CLK = ~CLK;

    // Serializer model: loads on Data_Valid && !Busy, shifts LSB first on ser_en.
    always @(posedge CLK) begin
        if (!RST) begin
            sreg <= 8'h00;
            scnt <= 3'd0;
        end else if (Data_Valid && !Busy) begin
            sreg <= P_DATA;
            scnt <= 3'd0;
        end else if (ser_en) begin
            sreg <= {1'b0, sreg[7:1]};
            scnt <= scnt + 3'd1;
        end
    end

    assign ser_data = sreg[0];
    assign ser_done = (ser_en && (scnt == 3'd7)) || force_done;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [10:0] exp;   // exp[10] is the first line bit after acceptance
        int          len;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, " tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, " ser_en"}, {31'd0, ser_en}, 32'd0);
    endtask

    // Called just after a falling edge; acceptance happens at the next rising edge.
    // mode 0: plain, mode 1: Data_Valid held through the frame, mode 2: mid-frame disturbance.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [10:0] exp, input int len, input int mode,
                             input logic [7:0] nd);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        if (mode != 1) Data_Valid = 1'b0;
        P_DATA = nd;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            chk($sformatf("tx d%02h c%0d", d, i), {31'd0, TX_OUT}, {31'd0, exp[10-i]});
            chk($sformatf("busy d%02h c%0d", d, i), {31'd0, Busy}, 32'd1);
            chk($sformatf("ser_en d%02h c%0d", d, i), {31'd0, ser_en},
                ((i >= 1) && (i <= 8)) ? 32'd1 : 32'd0);
            if (mode == 2) begin
                Data_Valid = (i == 3) || (i == 6);
                if (i == 4) PAR_TYP = ~PAR_TYP;
                PAR_EN     = (i == 5) ? ~pe : pe;
                force_done = (i == 0) || (i == 9);
            end
        end
        @(negedge CLK);
        check_idle($sformatf("post d%02h", d));
        if (mode == 2) begin
            @(negedge CLK);
            check_idle($sformatf("no extra d%02h", d));
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 11'b01010010111, 10};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 11'b01110000011, 11};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 11'b01110000001, 11};

        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        force_done = 1'b0;
        repeat (2) @(negedge CLK);
        check_idle("reset");
        RST = 1'b1;
        @(negedge CLK);
        check_idle("after reset");

        for (int v = 0; v < 3; v++) begin
            run_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].exp, vecs[v].len, 0,
                      vecs[v].data);
        end

        // Back-to-back with Data_Valid held: second byte taken in the lone IDLE cycle.
        run_frame(8'h3C, 1'b0, 1'b0, 11'b00011110011, 10, 1, 8'hC3);
        run_frame(8'hC3, 1'b0, 1'b0, 11'b01100001111, 10, 0, 8'hC3);

        // Mid-frame strobes, config changes and spurious ser_done must not disturb the frame.
        run_frame(8'hFF, 1'b1, 1'b0, 11'b01111111101, 11, 2, 8'hFF);

        // Reset during DATA bit 4 aborts the frame immediately.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        repeat (6) @(negedge CLK);
        chk("abort pre tx bit4", {31'd0, TX_OUT}, 32'd0);
        chk("abort pre busy", {31'd0, Busy}, 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        check_idle("abort");
        RST = 1'b1;
        @(negedge CLK);
        check_idle("abort release");
        run_frame(8'h55, 1'b0, 1'b0, 11'b01010101011, 10, 0, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
